// File: rtl/glip_uart_pkg.sv
// Shared constants and state encodings for the host-side UART control layer.
// Latency: n/a (package).
// Backpressure: n/a (package).
package glip_uart_pkg;

  // Escape byte that introduces every control sequence on the wire.
  localparam logic [7:0] ESC_BYTE    = 8'hfe;
  // Bit 7 set marks the first byte after ESC as the high half of a credit message.
  localparam logic [7:0] CREDIT_MARK = 8'h80;

  // Reset command selectors carried in bit 1 of the command byte.
  localparam logic CMD_LOGIC_RST = 1'b0;
  localparam logic CMD_COM_RST   = 1'b1;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_D0,
    TX_D1,
    TX_C0,
    TX_C1,
    TX_C2,
    TX_R0,
    TX_R1
  } tx_state_e;

  typedef enum logic [1:0] {
    RX_NORM,
    RX_ESCP,
    RX_CLO
  } rx_state_e;

  // Second byte of a reset command: {6'b0, sel, val}.
  function automatic logic [7:0] reset_cmd_byte(input logic sel, input logic val);
    return {6'b0, sel, val};
  endfunction

endpackage

// File: rtl/glip_uart_host_control_rx.sv
// Receive-side decoder: un-escapes device payload and extracts credit messages.
// Latency: accepted UART byte -> rx_out_valid next cycle; credit_en one cycle after the low credit byte.
// Backpressure: uart_rx_ready = !rx_out_valid || rx_out_ready, applied to every byte.
//
// Ports: clk/rst (sync, active-low); uart_rx_* byte input; rx_out_* one-entry
// payload buffer; com_rst forces the decoder back to NORM; credit_en/credit_val
// report a received credit grant; error is sticky until rst.
module glip_uart_host_control_rx
  import glip_uart_pkg::*;
#(
  parameter logic [7:0] ESC = ESC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  rx_out_data,
  output logic        rx_out_valid,
  input  logic        rx_out_ready,
  input  logic        com_rst,
  output logic        credit_en,
  output logic [13:0] credit_val,
  output logic        error
);

  rx_state_e  state, state_nxt;
  logic [6:0] hi;
  logic       accept;
  logic       emit;
  logic       hi_ld;
  logic       cr_ld;
  logic       err_set;
  logic       is_mark;

  assign uart_rx_ready = !rx_out_valid || rx_out_ready;
  assign accept        = uart_rx_valid && uart_rx_ready;
  assign is_mark       = (uart_rx_data & CREDIT_MARK) != 8'h00;

  always_comb begin
    state_nxt = state;
    emit      = 1'b0;
    hi_ld     = 1'b0;
    cr_ld     = 1'b0;
    err_set   = 1'b0;
    if (com_rst) begin
      // A com reset resynchronises the decoder; a byte arriving in the same
      // cycle is dropped.
      state_nxt = RX_NORM;
    end else if (accept) begin
      case (state)
        RX_NORM: begin
          if (uart_rx_data == ESC) state_nxt = RX_ESCP;
          else                     emit      = 1'b1;
        end
        RX_ESCP: begin
          state_nxt = RX_NORM;
          if (uart_rx_data == ESC) begin
            emit = 1'b1;
          end else if (is_mark) begin
            hi_ld     = 1'b1;
            state_nxt = RX_CLO;
          end else begin
            err_set = 1'b1;
          end
        end
        RX_CLO: begin
          state_nxt = RX_NORM;
          if (!is_mark) cr_ld   = 1'b1;
          else          err_set = 1'b1;
        end
        default: state_nxt = RX_NORM;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= RX_NORM;
      hi           <= 7'd0;
      rx_out_data  <= 8'd0;
      rx_out_valid <= 1'b0;
      credit_en    <= 1'b0;
      credit_val   <= 14'd0;
      error        <= 1'b0;
    end else begin
      state     <= state_nxt;
      credit_en <= cr_ld;
      if (hi_ld) hi <= uart_rx_data[6:0];
      if (cr_ld) credit_val <= {hi, uart_rx_data[6:0]};
      if (err_set) error <= 1'b1;
      // A new byte may only be emitted when the buffer is empty or draining.
      if (emit) begin
        rx_out_valid <= 1'b1;
        rx_out_data  <= uart_rx_data;
      end else if (rx_out_valid && rx_out_ready) begin
        rx_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/glip_uart_host_control.sv
// Host-end UART control layer: escapes host payload, sends credit grants and reset commands.
// Latency: a sequence starts the cycle after IDLE selects it; each byte lasts until uart_tx_done.
// Backpressure: payload waits for tx_credit != 0; every byte holds uart_tx_enable until uart_tx_done.
//
// Ports: clk/rst (sync, active-low); tx_in_* host payload (tx_in_ready pulses
// when an item is fully sent); uart_tx_* byte output with done handshake;
// uart_rx_* / rx_out_* via the rx decoder; cmd_* reset command request
// (cmd_ready pulses on the done of the command byte); tx_credit send credit;
// error sticky protocol / credit-overflow flag.
module glip_uart_host_control
  import glip_uart_pkg::*;
#(
  parameter int         HOST_CREDIT = 1024,
  parameter logic [7:0] ESC         = ESC_BYTE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  tx_in_data,
  input  logic        tx_in_valid,
  output logic        tx_in_ready,
  output logic [7:0]  uart_tx_data,
  output logic        uart_tx_enable,
  input  logic        uart_tx_done,
  input  logic [7:0]  uart_rx_data,
  input  logic        uart_rx_valid,
  output logic        uart_rx_ready,
  output logic [7:0]  rx_out_data,
  output logic        rx_out_valid,
  input  logic        rx_out_ready,
  input  logic        cmd_valid,
  input  logic        cmd_sel,
  input  logic        cmd_val,
  output logic        cmd_ready,
  output logic [14:0] tx_credit,
  output logic        error
);

  localparam logic [13:0] GRANT_FULL = 14'(HOST_CREDIT);
  localparam logic [13:0] GRANT_HALF = 14'(HOST_CREDIT / 2);

  tx_state_e   state, state_nxt;
  logic        grant_pnd;
  logic [13:0] grant_val;
  logic [14:0] consumed;
  logic [14:0] cnt_inc;
  logic [1:0]  cmd_q;
  logic        sat_err;
  logic        rx_err;
  logic        credit_en;
  logic [13:0] credit_val;
  logic [15:0] credit_sum;
  logic        pay_done;
  logic        grant_done;
  logic        cmd_done;
  logic        com_drop;
  logic        com_fresh;
  logic        rx_hs;

  glip_uart_host_control_rx #(
    .ESC (ESC)
  ) u_rx (
    .clk           (clk),
    .rst           (rst),
    .uart_rx_data  (uart_rx_data),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_ready (uart_rx_ready),
    .rx_out_data   (rx_out_data),
    .rx_out_valid  (rx_out_valid),
    .rx_out_ready  (rx_out_ready),
    .com_rst       (com_drop),
    .credit_en     (credit_en),
    .credit_val    (credit_val),
    .error         (rx_err)
  );

  assign error     = sat_err | rx_err;
  assign rx_hs     = rx_out_valid && rx_out_ready;
  // Com reset with val=1 drops all link state; val=0 re-announces the full buffer.
  assign com_drop  = cmd_done && (cmd_q[1] == CMD_COM_RST) && cmd_q[0];
  assign com_fresh = cmd_done && (cmd_q[1] == CMD_COM_RST) && !cmd_q[0];

  // ---------------- tx FSM ----------------
  always_ff @(posedge clk) begin
    if (!rst) state <= TX_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    uart_tx_data   = 8'd0;
    uart_tx_enable = 1'b0;
    tx_in_ready    = 1'b0;
    cmd_ready      = 1'b0;
    pay_done       = 1'b0;
    grant_done     = 1'b0;
    cmd_done       = 1'b0;
    case (state)
      TX_IDLE: begin
        if (cmd_valid)                              state_nxt = TX_R0;
        else if (grant_pnd)                         state_nxt = TX_C0;
        else if (tx_in_valid && tx_credit != 15'd0) state_nxt = TX_D0;
      end
      TX_D0: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = tx_in_data;
        if (uart_tx_done) begin
          if (tx_in_data == ESC) begin
            state_nxt = TX_D1;
          end else begin
            state_nxt   = TX_IDLE;
            tx_in_ready = 1'b1;
            pay_done    = 1'b1;
          end
        end
      end
      TX_D1: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = ESC;
        if (uart_tx_done) begin
          state_nxt   = TX_IDLE;
          tx_in_ready = 1'b1;
          pay_done    = 1'b1;
        end
      end
      TX_C0: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = ESC;
        if (uart_tx_done) state_nxt = TX_C1;
      end
      TX_C1: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = CREDIT_MARK | {1'b0, grant_val[13:7]};
        if (uart_tx_done) state_nxt = TX_C2;
      end
      TX_C2: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = {1'b0, grant_val[6:0]};
        if (uart_tx_done) begin
          state_nxt  = TX_IDLE;
          grant_done = 1'b1;
        end
      end
      TX_R0: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = ESC;
        if (uart_tx_done) state_nxt = TX_R1;
      end
      TX_R1: begin
        uart_tx_enable = 1'b1;
        uart_tx_data   = reset_cmd_byte(cmd_q[1], cmd_q[0]);
        if (uart_tx_done) begin
          state_nxt = TX_IDLE;
          cmd_ready = 1'b1;
          cmd_done  = 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

  // Command fields are captured when the sequence starts so the requester
  // does not have to hold them stable.
  always_ff @(posedge clk) begin
    if (!rst)                              cmd_q <= 2'b00;
    else if (state == TX_IDLE && cmd_valid) cmd_q <= {cmd_sel, cmd_val};
  end

  // ---------------- send credit ----------------
  // Incoming credit and an outgoing payload decrement may coincide; both apply.
  always_comb begin
    credit_sum = {1'b0, tx_credit}
               + (credit_en ? {2'b00, credit_val} : 16'd0)
               - {15'd0, pay_done};
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_credit <= 15'd0;
      sat_err   <= 1'b0;
    end else if (com_drop) begin
      tx_credit <= 15'd0;
    end else if (credit_sum > 16'd32767) begin
      tx_credit <= 15'h7fff;
      sat_err   <= 1'b1;
    end else begin
      tx_credit <= credit_sum[14:0];
    end
  end

  // ---------------- grant refill ----------------
  assign cnt_inc = consumed + {14'd0, rx_hs};

  always_ff @(posedge clk) begin
    if (!rst) begin
      grant_pnd <= 1'b1;
      grant_val <= GRANT_FULL;
      consumed  <= 15'd0;
    end else if (com_drop) begin
      grant_pnd <= 1'b0;
      consumed  <= 15'd0;
    end else begin
      consumed <= cnt_inc;
      if (com_fresh) begin
        grant_pnd <= 1'b1;
        grant_val <= GRANT_FULL;
      end else if (grant_done) begin
        grant_pnd <= 1'b0;
      end else if (!grant_pnd && cnt_inc >= {1'b0, GRANT_HALF}) begin
        // While a grant is still pending the counter keeps running; the
        // >= compare lets the refill fire as soon as that grant is out.
        grant_pnd <= 1'b1;
        grant_val <= GRANT_HALF;
        consumed  <= cnt_inc - {1'b0, GRANT_HALF};
      end
    end
  end

endmodule
